// File: rtl/rr_grant_arbiter.sv
// ----------------------------------------------------------------------------
// rr_grant_arbiter
//
// Purpose:
//   Round-robin arbiter with a locking grant. One requester is granted at a
//   time. The grant is registered, one-hot and held until the consumer acks,
//   or until the optional hold timer expires. After a release, priority
//   rotates to the index just past the winner. Re-arbitration happens in the
//   release cycle, so a waiting requester is granted without an idle bubble.
//
// Parameters:
//   NUM_REQ  number of requesters (>= 2, need not be a power of two)
//   TIMEOUT  maximum grant hold in cycles without ack; 0 disables the timer
//   PTR_W    width of the priority pointer (derived, do not override)
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   req          in   request vector, bit i = requester i
//   ack          in   consumer done with the current grant (ignored when idle)
//   grant        out  registered one-hot grant, all-zero when idle
//   grant_valid  out  registered, always equal to |grant
//   timeout      out  1-cycle pulse: the previous grant was revoked by the timer
//   state_dbg    out  FSM state for debug (0 = IDLE, 1 = BUSY)
//
// Handshake:
//   grant/grant_valid act as valid; ack acts as a one-cycle "done" strobe that
//   is only sampled while grant_valid=1. The grant never changes while
//   grant_valid=1 unless ack=1 or the hold timer fires in that same cycle.
// ----------------------------------------------------------------------------
module rr_grant_arbiter #(
    parameter int NUM_REQ = 8,
    parameter int TIMEOUT = 0,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               ack,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic               timeout,
    output logic               state_dbg
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;

    logic [PTR_W-1:0]   gidx;
    logic [PTR_W-1:0]   next_ptr;
    logic [PTR_W-1:0]   arb_ptr;
    logic [PTR_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_vec;
    logic               any_req;
    logic               rel_ev;
    logic               to_fire;

    assign state_dbg = (state == BUSY);
    assign any_req   = |req;

    // Binary index of the bit currently granted (grant is one-hot or zero).
    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gidx = PTR_W'(i);
            end
        end
    end

    // Explicit wrap so non-power-of-two NUM_REQ works.
    assign next_ptr = (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;

    // A release ends the current grant: ack wins over the timer.
    assign rel_ev  = (state == BUSY) && (ack || to_fire);

    // On a release, arbitrate with the rotated pointer in the same cycle.
    assign arb_ptr = rel_ev ? next_ptr : ptr;

    // Scan ptr, ptr+1, ... (mod NUM_REQ) and take the first active request.
    always_comb begin
        logic [PTR_W:0] idx_ext;
        logic           found;
        win_idx = '0;
        found   = 1'b0;
        idx_ext = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_ext = {1'b0, arb_ptr} + (PTR_W+1)'(k);
            if (idx_ext >= (PTR_W+1)'(NUM_REQ)) begin
                idx_ext = idx_ext - (PTR_W+1)'(NUM_REQ);
            end
            if (!found && req[idx_ext[PTR_W-1:0]]) begin
                found   = 1'b1;
                win_idx = idx_ext[PTR_W-1:0];
            end
        end
    end

    assign win_vec = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;

    // Hold timer. Counts cycles the current grant has been held; it is
    // cleared while idle and on every release so each new grant starts at 0.
    generate
        if (TIMEOUT > 0) begin : g_timer
            localparam int CNT_W = $clog2(TIMEOUT + 1);
            logic [CNT_W-1:0] hold_cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hold_cnt <= '0;
                end else if (state == IDLE || rel_ev) begin
                    hold_cnt <= '0;
                end else if (hold_cnt != {CNT_W{1'b1}}) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end

            // Fires on the last permitted hold cycle; suppressed by ack.
            assign to_fire = (state == BUSY) && !ack &&
                             (hold_cnt == CNT_W'(TIMEOUT - 1));
        end else begin : g_no_timer
            assign to_fire = 1'b0;
        end
    endgenerate

    // Main FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    timeout <= 1'b0;
                    if (any_req) begin
                        state       <= BUSY;
                        grant       <= win_vec;
                        grant_valid <= 1'b1;
                    end
                end
                BUSY: begin
                    if (rel_ev) begin
                        ptr     <= next_ptr;
                        timeout <= to_fire;
                        if (any_req) begin
                            grant       <= win_vec;
                            grant_valid <= 1'b1;
                        end else begin
                            state       <= IDLE;
                            grant       <= '0;
                            grant_valid <= 1'b0;
                        end
                    end else begin
                        timeout <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    grant       <= '0;
                    grant_valid <= 1'b0;
                    timeout     <= 1'b0;
                end
            endcase
        end
    end

endmodule
